rx_decimator: RTL and testbench

RX_DECIMATOR -- requirements
Module: rx_decimator

---
 rtl/rx_pkg.sv | 16 +
 rtl/ber_counter.sv | 39 +++
 rtl/rx_decimator.sv | 85 ++++++++
 tb/tb_rx_decimator.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared defaults and helpers for the receiver decimator and its BER counter.
// The sign of an S(8,7) sample is its MSB, which doubles as the hard decision.
package rx_pkg;

  localparam int NB_INPUT = 8;
  localparam int OS       = 4;
  localparam int NB_CNT   = 32;
  localparam int NB_PHASE = $clog2(OS);

  // Number of hard decisions (0, 1 or 2) that disagree with the reference bits.
  function automatic logic [1:0] mismatch_count(input logic sign_i, input logic ref_i,
                                                input logic sign_q, input logic ref_q);
    mismatch_count = {1'b0, sign_i ^ ref_i} + {1'b0, sign_q ^ ref_q};
  endfunction

endpackage

// File: rtl/ber_counter.sv
// Saturating error / compared-bit counters for the decimator's hard decisions.
// Clear wins over a simultaneous capture, so that symbol is never counted.
module ber_counter #(
  parameter int NB_CNT = rx_pkg::NB_CNT
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_capture,
  input  logic              i_clear,
  input  logic [1:0]        i_mismatch,
  output logic [NB_CNT-1:0] o_err_count,
  output logic [NB_CNT-1:0] o_bit_count
);

  logic [NB_CNT:0]   err_sum;
  logic [NB_CNT:0]   bit_sum;
  logic [NB_CNT-1:0] err_next;
  logic [NB_CNT-1:0] bit_next;

  // One extra bit catches the overflow carry; on carry the counter pins at all-ones.
  assign err_sum  = {1'b0, o_err_count} + (NB_CNT+1)'(i_mismatch);
  assign bit_sum  = {1'b0, o_bit_count} + (NB_CNT+1)'(2);
  assign err_next = err_sum[NB_CNT] ? '1 : err_sum[NB_CNT-1:0];
  assign bit_next = bit_sum[NB_CNT] ? '1 : bit_sum[NB_CNT-1:0];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_err_count <= '0;
      o_bit_count <= '0;
    end else if (i_clear) begin
      o_err_count <= '0;
      o_bit_count <= '0;
    end else if (i_capture) begin
      o_err_count <= err_next;
      o_bit_count <= bit_next;
    end
  end

endmodule

// File: rtl/rx_decimator.sv
// Picks one sample per OS-sample symbol period at a programmable phase, makes
// sign decisions and accumulates bit errors against a local reference PRBS.
module rx_decimator #(
  parameter int NB_INPUT = rx_pkg::NB_INPUT,
  parameter int OS       = rx_pkg::OS,
  parameter int NB_CNT   = rx_pkg::NB_CNT
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [$clog2(OS)-1:0] i_phase,
  input  logic [NB_INPUT-1:0]   i_symb_I,
  input  logic [NB_INPUT-1:0]   i_symb_Q,
  input  logic                  i_ref_I,
  input  logic                  i_ref_Q,
  input  logic                  i_clear,
  output logic                  o_valid,
  output logic [NB_INPUT-1:0]   o_symb_I,
  output logic [NB_INPUT-1:0]   o_symb_Q,
  output logic                  o_bit_I,
  output logic                  o_bit_Q,
  output logic [NB_CNT-1:0]     o_err_count,
  output logic [NB_CNT-1:0]     o_bit_count
);

  import rx_pkg::*;

  localparam int                  PHASE_W    = $clog2(OS);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(OS - 1);

  logic [PHASE_W-1:0] cnt;
  logic [PHASE_W-1:0] phase_r;
  logic               capture;
  logic               wrap;
  logic [1:0]         mismatch;

  assign capture  = i_valid && (cnt == phase_r);
  assign wrap     = i_valid && (cnt == LAST_PHASE);
  assign mismatch = mismatch_count(i_symb_I[NB_INPUT-1], i_ref_I,
                                   i_symb_Q[NB_INPUT-1], i_ref_Q);

  // A new phase only takes effect at the symbol boundary, so the symbol in
  // flight is still captured once at the old phase and none is lost or doubled.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cnt     <= '0;
      phase_r <= '0;
    end else if (i_valid) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) begin
        phase_r <= i_phase;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_valid  <= 1'b0;
      o_symb_I <= '0;
      o_symb_Q <= '0;
    end else begin
      o_valid <= capture;
      if (capture) begin
        o_symb_I <= i_symb_I;
        o_symb_Q <= i_symb_Q;
      end
    end
  end

  assign o_bit_I = o_symb_I[NB_INPUT-1];
  assign o_bit_Q = o_symb_Q[NB_INPUT-1];

  ber_counter #(
    .NB_CNT (NB_CNT)
  ) u_ber_counter (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_capture   (capture),
    .i_clear     (i_clear),
    .i_mismatch  (mismatch),
    .o_err_count (o_err_count),
    .o_bit_count (o_bit_count)
  );

endmodule

// File: tb/tb_rx_decimator.sv
// Bench for rx_decimator: directed scenarios then random traffic, checked each
// cycle against a sample-index model; a second instance uses 4-bit counters.
module tb_rx_decimator;

  localparam int OS = 4;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_valid = 1'b0;
  logic [1:0] i_phase = '0;
  logic [7:0] i_symb_I = '0;
  logic [7:0] i_symb_Q = '0;
  logic       i_ref_I = 1'b0;
  logic       i_ref_Q = 1'b0;
  logic       i_clear = 1'b0;

  logic        o_valid, o_bit_I, o_bit_Q;
  logic [7:0]  o_symb_I, o_symb_Q;
  logic [31:0] o_err_count, o_bit_count;
  logic        o_valid4, o_bit_I4, o_bit_Q4;
  logic [7:0]  o_symb_I4, o_symb_Q4;
  logic [3:0]  o_err_count4, o_bit_count4;

  int evaluated = 0;
  int failures  = 0;

  // reference model state
  int          vidx, phase_eff;
  logic        exp_valid;
  logic [7:0]  exp_I, exp_Q;
  longint      err_big, bit_big, err_small, bit_small;
  int          pulses;

  always #5 i_clock = ~i_clock;

  rx_decimator #(.NB_INPUT(8), .OS(OS), .NB_CNT(32)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_phase(i_phase),
    .i_symb_I(i_symb_I), .i_symb_Q(i_symb_Q), .i_ref_I(i_ref_I), .i_ref_Q(i_ref_Q),
    .i_clear(i_clear), .o_valid(o_valid), .o_symb_I(o_symb_I), .o_symb_Q(o_symb_Q),
    .o_bit_I(o_bit_I), .o_bit_Q(o_bit_Q), .o_err_count(o_err_count), .o_bit_count(o_bit_count)
  );

  rx_decimator #(.NB_INPUT(8), .OS(OS), .NB_CNT(4)) dut4 (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_phase(i_phase),
    .i_symb_I(i_symb_I), .i_symb_Q(i_symb_Q), .i_ref_I(i_ref_I), .i_ref_Q(i_ref_Q),
    .i_clear(i_clear), .o_valid(o_valid4), .o_symb_I(o_symb_I4), .o_symb_Q(o_symb_Q4),
    .o_bit_I(o_bit_I4), .o_bit_Q(o_bit_Q4), .o_err_count(o_err_count4), .o_bit_count(o_bit_count4)
  );

  function automatic longint sat_add(input longint a, input longint b, input longint top);
    sat_add = (a + b > top) ? top : a + b;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    evaluated++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string pfx);
    checkOutput({pfx, ".valid"},  32'(o_valid),  32'(exp_valid));
    checkOutput({pfx, ".symb_I"}, 32'(o_symb_I), 32'(exp_I));
    checkOutput({pfx, ".symb_Q"}, 32'(o_symb_Q), 32'(exp_Q));
    checkOutput({pfx, ".bit_I"},  32'(o_bit_I),  32'(exp_I[7]));
    checkOutput({pfx, ".bit_Q"},  32'(o_bit_Q),  32'(exp_Q[7]));
    checkOutput({pfx, ".err"},    o_err_count,   32'(err_big));
    checkOutput({pfx, ".bits"},   o_bit_count,   32'(bit_big));
    checkOutput({pfx, ".valid4"}, 32'(o_valid4), 32'(exp_valid));
    checkOutput({pfx, ".err4"},   32'(o_err_count4), 32'(err_small));
    checkOutput({pfx, ".bits4"},  32'(o_bit_count4), 32'(bit_small));
  endtask

  task automatic modelReset();
    vidx = 0; phase_eff = 0; exp_valid = 1'b0; exp_I = '0; exp_Q = '0;
    err_big = 0; bit_big = 0; err_small = 0; bit_small = 0;
  endtask

  function automatic bit willCapture(input logic v);
    willCapture = v && ((vidx % OS) == phase_eff);
  endfunction

  // One clock: drive at the falling edge, advance the model at the rising edge,
  // compare at the next falling edge.
  task automatic applyStimulus(input logic v, input logic [1:0] ph, input logic [7:0] si,
                               input logic [7:0] sq, input logic ri, input logic rq,
                               input logic clr, input string pfx);
    int k, mm;
    i_valid = v; i_phase = ph; i_symb_I = si; i_symb_Q = sq;
    i_ref_I = ri; i_ref_Q = rq; i_clear = clr;
    @(posedge i_clock);
    exp_valid = 1'b0;
    if (v) begin
      k = vidx % OS;
      if (k == phase_eff) begin
        exp_valid = 1'b1; exp_I = si; exp_Q = sq;
        mm = int'(si[7] != ri) + int'(sq[7] != rq);
        err_big   = sat_add(err_big, longint'(mm), 64'hFFFF_FFFF);
        bit_big   = sat_add(bit_big, 2, 64'hFFFF_FFFF);
        err_small = sat_add(err_small, longint'(mm), 15);
        bit_small = sat_add(bit_small, 2, 15);
      end
      if (k == OS - 1) phase_eff = int'(ph);
      vidx++;
    end
    if (clr) begin
      err_big = 0; bit_big = 0; err_small = 0; bit_small = 0;
    end
    @(negedge i_clock);
    checkAll(pfx);
    if (o_valid) pulses++;
  endtask

  task automatic resetDut();
    i_reset = 1'b1; i_valid = 1'b0; i_clear = 1'b0;
    #1;
    modelReset();
    checkAll("reset");
    @(negedge i_clock);
    i_reset = 1'b0;
  endtask

  initial begin
    logic [7:0] pat [4];
    pat[0] = 8'h10; pat[1] = 8'h01; pat[2] = 8'h02; pat[3] = 8'h03;
    modelReset();
    @(negedge i_clock);
    resetDut();

    // phase 0, continuous valid, repeating pattern: capture of 0x10 every 4th cycle
    pulses = 0;
    for (int n = 0; n < 16; n++)
      applyStimulus(1'b1, 2'd0, pat[n % 4], pat[n % 4], 1'b0, 1'b0, 1'b0, "pat");
    checkOutput("pat.pulses", 32'(pulses), 32'd4);
    checkOutput("pat.symb_I_const", 32'(o_symb_I), 32'h10);

    // phase 2 established, then changed to 1 mid-symbol at cnt=1
    resetDut();
    pulses = 0;
    for (int n = 0; n < 4; n++)
      applyStimulus(1'b1, 2'd2, 8'(n), 8'(n), 1'b0, 1'b0, 1'b0, "ph2");
    applyStimulus(1'b1, 2'd2, 8'h20, 8'h20, 1'b0, 1'b0, 1'b0, "ph2");
    for (int n = 1; n < 12; n++)
      applyStimulus(1'b1, 2'd1, 8'(8'h20 + n), 8'(n), 1'b0, 1'b0, 1'b0, "ph1");
    checkOutput("phase.pulses", 32'(pulses), 32'd4);

    // i_valid toggling: symbol period doubles to 8 clocks
    resetDut();
    pulses = 0;
    for (int n = 0; n < 32; n++)
      applyStimulus(1'(n % 2 == 0), 2'd0, 8'(n * 3), 8'(n * 5), 1'b1, 1'b0, 1'b0, "tog");
    checkOutput("tog.pulses", 32'(pulses), 32'd4);

    // I=0x80, Q=0x7F with zero reference bits: one error, two bits
    resetDut();
    for (int n = 0; n < 4; n++)
      applyStimulus(1'b1, 2'd0, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b0, "sign");
    checkOutput("sign.bit_I", 32'(o_bit_I), 32'd1);
    checkOutput("sign.err", o_err_count, 32'd1);
    checkOutput("sign.bits", o_bit_count, 32'd2);

    // two mismatches per symbol drive the 4-bit error counter into saturation
    for (int n = 0; n < 40; n++)
      applyStimulus(1'b1, 2'd0, 8'h40, 8'h40, 1'b1, 1'b1, 1'b0, "sat");
    checkOutput("sat.err4", 32'(o_err_count4), 32'd15);
    checkOutput("sat.err32", o_err_count, 32'd21);
    // clear coincident with a capture
    while (!willCapture(1'b1))
      applyStimulus(1'b1, 2'd0, 8'h40, 8'h40, 1'b1, 1'b1, 1'b0, "preclr");
    applyStimulus(1'b1, 2'd0, 8'h40, 8'h40, 1'b1, 1'b1, 1'b1, "clrcap");
    checkOutput("clrcap.err", o_err_count, 32'd0);
    checkOutput("clrcap.bits4", 32'(o_bit_count4), 32'd0);

    // reset pulse at cnt=2 mid-stream
    resetDut();
    applyStimulus(1'b1, 2'd0, 8'h55, 8'hAA, 1'b0, 1'b1, 1'b0, "mid");
    applyStimulus(1'b1, 2'd0, 8'h66, 8'h99, 1'b0, 1'b1, 1'b0, "mid");
    #2;
    i_reset = 1'b1; i_valid = 1'b0;
    #1;
    modelReset();
    checkAll("midrst");
    @(negedge i_clock);
    i_reset = 1'b0;
    applyStimulus(1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "idle");
    applyStimulus(1'b1, 2'd0, 8'h77, 8'h88, 1'b1, 1'b1, 1'b0, "post");
    checkOutput("post.valid", 32'(o_valid), 32'd1);
    checkOutput("post.symb_I", 32'(o_symb_I), 32'h77);

    // random traffic against the model
    for (int n = 0; n < 600; n++)
      applyStimulus(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom), 8'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom_range(0, 29) == 0), "rnd");

    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule
